// File: rtl/z80_bus_target.sv
// Z80 slave bus responder: turns CPU strobes into one req/ack backend transaction, stretching the CPU via wait_n.
// Define Z80_TGT_INTACK_EN to answer IM2 interrupt-acknowledge cycles with irq_vec and drive int_n from irq.
module z80_bus_target #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq,
  input  logic [7:0]  irq_vec,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        be_we_q, be_we_d;
  logic        be_io_q, be_io_d;
  logic [15:0] be_addr_q, be_addr_d;
  logic [7:0]  be_wdata_q, be_wdata_d;
  logic [7:0]  cpu_di_q, cpu_di_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  inta_data;
  logic        cyc;
  logic        inta;

  assign cyc  = (~mreq_n | (~iorq_n & m1_n)) & (~rd_n | ~wr_n);
  assign inta = ~iorq_n & ~m1_n;

`ifdef Z80_TGT_INTACK_EN
  logic int_n_q, int_n_d;

  always_comb int_n_d = ~irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) int_n_q <= 1'b1;
    else       int_n_q <= int_n_d;
  end

  assign int_n     = int_n_q;
  assign inta_data = irq_vec;
`else
  logic unused_irq;

  assign unused_irq = ^{irq, irq_vec};
  assign int_n      = 1'b1;
  assign inta_data  = IDLE_DATA;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    be_we_d    = be_we_q;
    be_io_d    = be_io_q;
    be_addr_d  = be_addr_q;
    be_wdata_d = be_wdata_q;
    cpu_di_d   = cpu_di_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc) begin
          be_addr_d  = A;
          be_wdata_d = cpu_dout;
          be_we_d    = ~wr_n;
          be_io_d    = ~iorq_n;
          cnt_d      = 8'd0;
          state_d    = REQ;
        end else if (inta) begin
          cpu_di_d = inta_data;
          state_d  = HOLD;
        end
      end
      REQ: begin
        // An ack landing on the last counted cycle still wins over the timeout.
        if (be_ack) begin
          if (!be_we_q) cpu_di_d = be_rdata;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          cpu_di_d  = IDLE_DATA;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (!cyc && !inta) begin
          cpu_di_d = IDLE_DATA;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      be_we_q    <= 1'b0;
      be_io_q    <= 1'b0;
      be_addr_q  <= 16'd0;
      be_wdata_q <= 8'd0;
      cpu_di_q   <= IDLE_DATA;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      be_we_q    <= be_we_d;
      be_io_q    <= be_io_d;
      be_addr_q  <= be_addr_d;
      be_wdata_q <= be_wdata_d;
      cpu_di_q   <= cpu_di_d;
      timeout_q  <= timeout_d;
    end
  end

  // Reset must release the CPU even while its strobes are still asserted.
  assign wait_n   = reset | ~(((state_q == IDLE) & cyc) | (state_q == REQ));
  assign be_req   = (state_q == REQ);
  assign be_we    = be_we_q;
  assign be_io    = be_io_q;
  assign be_addr  = be_addr_q;
  assign be_wdata = be_wdata_q;
  assign cpu_di   = cpu_di_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Scoreboard bench for z80_bus_target: random CPU cycles, a backend responder and a CPU-side monitor.
module tb_z80_bus_target;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        wait_n, int_n;
  logic        irq;
  logic [7:0]  irq_vec;
  logic        be_req, be_we, be_io;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic [7:0]  be_rdata = 8'h00;
  logic        be_ack = 1'b0;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  z80_bus_target #(.TIMEOUT(TMO), .IDLE_DATA(8'hFF)) dut (
    .clk(clk), .reset(rst), .A(A), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .cpu_dout(cpu_dout), .cpu_di(cpu_di), .wait_n(wait_n),
    .int_n(int_n), .irq(irq), .irq_vec(irq_vec), .be_req(be_req), .be_we(be_we),
    .be_io(be_io), .be_addr(be_addr), .be_wdata(be_wdata), .be_rdata(be_rdata),
    .be_ack(be_ack), .timeout(timeout)
  );

  typedef struct {
    logic        we;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          delay;
    logic [7:0]  rdata;
    int          len;
  } be_exp_t;

  typedef struct {
    logic [7:0] di;
    int         to;
  } cpu_exp_t;

  be_exp_t  be_q[$];
  cpu_exp_t cpu_q[$];
  int       done_cnt = 0;
  int       be_done  = 0;
  logic     in_cycle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backend side: checks request fields at be_req rise, length/stability at fall, and answers with be_ack.
  be_exp_t cur;
  logic    b_act = 1'b0;
  int      k = 0, blen = 0;
  logic    bstable, bwait;

  always @(negedge clk) begin
    if (rst) begin
      b_act  = 1'b0;
      be_ack = 1'b0;
    end else if (be_req) begin
      if (!b_act) begin
        b_act = 1'b1; k = 0; blen = 0; bstable = 1'b1; bwait = 1'b0;
        if (be_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL be_unexpected: got be_req=1 expected no request at %0t", $time);
          cur.we = be_we; cur.io = be_io; cur.addr = be_addr; cur.wdata = be_wdata;
          cur.delay = 0; cur.rdata = 8'h00; cur.len = -1;
        end else begin
          cur = be_q.pop_front();
          check("be_we", be_we, cur.we);
          check("be_io", be_io, cur.io);
          check("be_addr", be_addr, cur.addr);
          check("be_wdata", be_wdata, cur.wdata);
        end
      end else begin
        k++;
      end
      blen++;
      if ({be_we, be_io, be_addr, be_wdata} !== {cur.we, cur.io, cur.addr, cur.wdata}) bstable = 1'b0;
      if (wait_n !== 1'b0) bwait = 1'b1;
      be_ack   = (k == cur.delay);
      be_rdata = (k == cur.delay) ? cur.rdata : 8'($urandom);
    end else begin
      if (b_act) begin
        b_act = 1'b0;
        check("be_len", blen, cur.len);
        check("be_stable", bstable, 1);
        check("wait_high_in_req", bwait, 0);
        be_done++;
      end
      // Acks outside a request must be ignored by the target.
      be_ack   = ($urandom_range(0, 3) == 0);
      be_rdata = 8'($urandom);
    end
  end

  // CPU side: a cycle completes at the first sample past its opening clock where wait_n is high.
  logic     prev_act = 1'b0, reported = 1'b0;
  int       to_cnt = 0;
  cpu_exp_t ce_mon;

  always @(negedge clk) begin
    if (rst) begin
      prev_act = 1'b0; reported = 1'b0; to_cnt = 0;
    end else begin
      if (timeout === 1'b1) to_cnt++;
      if (in_cycle && prev_act && wait_n === 1'b1 && !reported) begin
        reported = 1'b1;
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: got completion with cpu_di=%0h expected none", cpu_di);
        end else begin
          ce_mon = cpu_q.pop_front();
          check("cpu_di", cpu_di, ce_mon.di);
          check("timeout_pulses", to_cnt, ce_mon.to);
        end
        to_cnt = 0;
        done_cnt++;
      end
      if (!in_cycle) reported = 1'b0;
      prev_act = in_cycle;
    end
  end

  task automatic idle_bus();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  // op: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 mem rd+wr, 5 opcode fetch, 6 int ack
  task automatic drive_op(input int op);
    idle_bus();
    case (op)
      0: begin mreq_n = 1'b0; rd_n = 1'b0; end
      1: begin mreq_n = 1'b0; wr_n = 1'b0; end
      2: begin iorq_n = 1'b0; rd_n = 1'b0; end
      3: begin iorq_n = 1'b0; wr_n = 1'b0; end
      4: begin mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; end
      5: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      default: begin m1_n = 1'b0; iorq_n = 1'b0; end
    endcase
  endtask

  function automatic be_exp_t model_be(input int op, input int delay, input logic [15:0] a,
                                        input logic [7:0] wd, input logic [7:0] rd);
    be_exp_t e;
    e.we = (op == 1 || op == 3 || op == 4);
    e.io = (op == 2 || op == 3);
    e.addr = a; e.wdata = wd; e.delay = delay; e.rdata = rd;
    e.len = (delay < TMO) ? delay + 1 : TMO;
    return e;
  endfunction

  task automatic do_cycle(input int op, input int delay, input logic [15:0] a,
                          input logic [7:0] wd, input logic [7:0] rd);
    be_exp_t  be;
    cpu_exp_t ce;
    int       start;
    @(posedge clk); #1;
    A = a; cpu_dout = wd;
    drive_op(op);
    if (op != 6) begin
      be = model_be(op, delay, a, wd, rd);
      be_q.push_back(be);
      ce.di = (!be.we && delay < TMO) ? rd : 8'hFF;
      ce.to = (delay < TMO) ? 0 : 1;
    end else begin
`ifdef Z80_TGT_INTACK_EN
      ce.di = irq_vec;
`else
      ce.di = 8'hFF;
`endif
      ce.to = 0;
    end
    cpu_q.push_back(ce);
    in_cycle = 1'b1;
    start = done_cnt;
    for (int i = 0; i < 200 && done_cnt == start; i++) @(posedge clk);
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL cycle_done: got no completion expected one within 200 cycles (op %0d)", op);
      cpu_q.delete(); be_q.delete();
    end
    #1;
    idle_bus();
    in_cycle = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Strobes vanish mid-request: the request must still run to its ack, then drop straight to idle.
  task automatic do_abort(input int delay);
    int start;
    @(posedge clk); #1;
    A = 16'($urandom); cpu_dout = 8'($urandom);
    be_q.push_back(model_be(0, delay, A, cpu_dout, 8'h3C));
    drive_op(0);
    repeat (2) @(posedge clk);
    #1;
    idle_bus();
    start = be_done;
    for (int i = 0; i < 100 && be_done == start; i++) @(posedge clk);
    if (be_done == start) begin
      checks++; errors++;
      $display("FAIL abort_done: got be_req still high expected completion");
    end
    @(posedge clk); #1;
    check("abort_wait_n", wait_n, 1'b1);
    check("abort_cpu_di", cpu_di, 8'hFF);
  endtask

  initial begin
    int r, op, dly;
    rst = 1'b1; A = 16'h0000; cpu_dout = 8'h00; irq = 1'b0; irq_vec = 8'h00;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check("rst_be_req", be_req, 1'b0);
    check("rst_be_we", be_we, 1'b0);
    check("rst_be_io", be_io, 1'b0);
    check("rst_be_addr", be_addr, 16'h0000);
    check("rst_be_wdata", be_wdata, 8'h00);
    check("rst_cpu_di", cpu_di, 8'hFF);
    check("rst_timeout", timeout, 1'b0);
    check("rst_wait_n", wait_n, 1'b1);
    check("rst_int_n", int_n, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    do_cycle(0, 2, 16'h1234, 8'h00, 8'hA5);
    do_cycle(3, 1, 16'h0042, 8'h5C, 8'h00);
    do_cycle(0, 1000, 16'hBEEF, 8'h11, 8'h22);
    do_cycle(0, TMO - 1, 16'h8001, 8'h00, 8'h6B);
    do_cycle(2, TMO, 16'h00FE, 8'h00, 8'h77);
    do_cycle(4, 0, 16'h4000, 8'h99, 8'h12);

    irq = 1'b1; irq_vec = 8'hE0;
    repeat (2) @(posedge clk);
    #1;
`ifdef Z80_TGT_INTACK_EN
    check("int_n_asserted", int_n, 1'b0);
`else
    check("int_n_asserted", int_n, 1'b1);
`endif
    do_cycle(6, 0, 16'h00FF, 8'h00, 8'h00);
    irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("int_n_released", int_n, 1'b1);

    do_abort(3);

    // Reset while a request is outstanding and the CPU strobes are still asserted.
    @(posedge clk); #1;
    A = 16'h5555; cpu_dout = 8'hAA;
    be_q.push_back(model_be(0, 1000, A, cpu_dout, 8'h00));
    drive_op(0);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_be_req", be_req, 1'b0);
    check("midrst_wait_n", wait_n, 1'b1);
    check("midrst_cpu_di", cpu_di, 8'hFF);
    check("midrst_timeout", timeout, 1'b0);
    check("midrst_be_addr", be_addr, 16'h0000);
    idle_bus();
    @(negedge clk); #1;
    be_q.delete(); cpu_q.delete();
    rst = 1'b0;
    do_cycle(1, 0, 16'h2222, 8'h33, 8'h00);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 6);
      r  = $urandom_range(0, 9);
      dly = (r < 8) ? $urandom_range(0, 6) : ((r == 8) ? $urandom_range(TMO - 4, TMO + 2) : 1000);
      if (op == 6) begin
        irq_vec = 8'($urandom);
        irq = 1'($urandom);
      end
      do_cycle(op, dly, 16'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (4) @(posedge clk);
    check("be_q_drained", be_q.size(), 0);
    check("cpu_q_drained", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
